// File: rtl/channel_normalizer.sv
// channel_normalizer
// Collects one complex channel matrix from a gappy ready/valid source,
// applies one block-floating-point left shift so the largest component
// fills the dynamic range, and re-emits the matrix as one contiguous
// valid burst for the bidiagonalization core.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake, transfer when both high
//   in_R, in_I        signed input components
//   R_o, I_o          normalized components, zero while valid_o is low
//   valid_o           high for CHANNEL_SIZE consecutive cycles per matrix
//   shift_o           shift applied to the current/last matrix
//   busy              high in every state except COLLECT
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | accepting entries, accumulating magnitude OR into r_m
// SCALE   | one cycle: leading-zero count of r_m latched into shift_o
// EMIT    | CHANNEL_SIZE cycles: stored entries shifted and output
// GAP     | one cycle of valid_o low, accumulator and counter cleared
module channel_normalizer #(
    parameter int BIT_NUM      = 18,
    parameter int CHANNEL_SIZE = 16,
    parameter int MAX_SHIFT    = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic signed [BIT_NUM-1:0]          in_R,
    input  logic signed [BIT_NUM-1:0]          in_I,
    output logic                               in_ready,
    output logic signed [BIT_NUM-1:0]          R_o,
    output logic signed [BIT_NUM-1:0]          I_o,
    output logic                               valid_o,
    output logic [$clog2(MAX_SHIFT+1)-1:0]     shift_o,
    output logic                               busy
);

    localparam int CNT_W = $clog2(CHANNEL_SIZE);
    localparam int SH_W  = $clog2(MAX_SHIFT + 1);
    localparam int LZ_W  = $clog2(BIT_NUM);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_SCALE   = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    logic [1:0]                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [BIT_NUM-2:0]        r_m;
    logic [SH_W-1:0]           r_shift;
    logic signed [BIT_NUM-1:0] r_r_o;
    logic signed [BIT_NUM-1:0] r_i_o;
    logic                      r_valid;
    logic signed [BIT_NUM-1:0] r_mem_r [CHANNEL_SIZE];
    logic signed [BIT_NUM-1:0] r_mem_i [CHANNEL_SIZE];

    logic                      w_xfer;
    logic                      w_last;
    logic [BIT_NUM-2:0]        w_mag;
    logic [LZ_W-1:0]           w_lz;
    logic [SH_W-1:0]           w_shift;

    assign w_xfer = in_valid && (r_state == S_COLLECT);
    assign w_last = (r_cnt == CNT_W'(CHANNEL_SIZE - 1));

    // XOR with the sign turns each component into a "distance from sign
    // extension" pattern; its MSB is always zero so only the low bits are kept.
    assign w_mag = (in_R[BIT_NUM-2:0] ^ {(BIT_NUM-1){in_R[BIT_NUM-1]}})
                 | (in_I[BIT_NUM-2:0] ^ {(BIT_NUM-1){in_I[BIT_NUM-1]}});

    // Leading zeros of r_m; highest set bit wins because it is visited last.
    always_comb begin
        w_lz = LZ_W'(BIT_NUM - 1);
        for (int i = 0; i < BIT_NUM - 1; i++) begin
            if (r_m[i]) begin
                w_lz = LZ_W'(BIT_NUM - 2 - i);
            end
        end
    end

    assign w_shift = (w_lz > LZ_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : w_lz[SH_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_m     <= '0;
            r_shift <= '0;
            r_r_o   <= '0;
            r_i_o   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_r_o   <= '0;
            r_i_o   <= '0;
            case (r_state)
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_m <= r_m | w_mag;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= S_SCALE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_SCALE: begin
                    r_shift <= w_shift;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    // Shifted-out bits are sign copies, so no saturation needed.
                    r_valid <= 1'b1;
                    r_r_o   <= r_mem_r[r_cnt] <<< r_shift;
                    r_i_o   <= r_mem_i[r_cnt] <<< r_shift;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    r_m     <= '0;
                    r_cnt   <= '0;
                    r_state <= S_COLLECT;
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_xfer) begin
            r_mem_r[r_cnt] <= in_R;
            r_mem_i[r_cnt] <= in_I;
        end
    end

    assign in_ready = (r_state == S_COLLECT);
    assign busy     = (r_state != S_COLLECT);
    assign R_o      = r_r_o;
    assign I_o      = r_i_o;
    assign valid_o  = r_valid;
    assign shift_o  = r_shift;

endmodule

// File: tb/tb_channel_normalizer.sv
// tb_channel_normalizer
// Scoreboard bench: each matrix load pushes its expected normalized
// entries (from an independent range-based shift model) into a queue; a
// negedge monitor pops and compares them whenever valid_o is high, and
// checks burst length, latency and idle-zero outputs.
module tb_channel_normalizer;

    typedef struct {
        logic signed [17:0] r;
        logic signed [17:0] i;
        logic [2:0]         sh;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [17:0] in_R;
    logic signed [17:0] in_I;
    logic               in_ready;
    logic signed [17:0] R_o;
    logic signed [17:0] I_o;
    logic               valid_o;
    logic [2:0]         shift_o;
    logic               busy;

    exp_t               q[$];
    exp_t               mon_e;
    logic signed [17:0] mat_r [16];
    logic signed [17:0] mat_i [16];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_xfer = 0;
    int run = 0;
    int seen = 0;
    int bursts = 0;
    bit abort = 1'b0;
    bit mon_en = 1'b0;

    channel_normalizer #(.BIT_NUM(18), .CHANNEL_SIZE(16), .MAX_SHIFT(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_R     (in_R),
        .in_I     (in_I),
        .in_ready (in_ready),
        .R_o      (R_o),
        .I_o      (I_o),
        .valid_o  (valid_o),
        .shift_o  (shift_o),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Largest s <= 7 such that every component fits in (18 - s) signed bits.
    function automatic int model_shift();
        int s = 7;
        int v;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 2; c++) begin
                v = (c == 0) ? int'(mat_r[k]) : int'(mat_i[k]);
                while (s > 0 && (v < -(1 << (17 - s)) || v >= (1 << (17 - s))))
                    s--;
            end
        end
        return s;
    endfunction

    // mode 0: back-to-back, 1: idle cycle between entries,
    // 2: in_valid held high with junk data while in_ready is low.
    task automatic load(input int mode, input bit hold_after);
        int   s;
        int   p;
        int   b;
        exp_t e;
        s = model_shift();
        for (int k = 0; k < 16; k++) begin
            p    = int'(mat_r[k]) * (1 << s);
            e.r  = 18'(p);
            p    = int'(mat_i[k]) * (1 << s);
            e.i  = 18'(p);
            e.sh = 3'(s);
            q.push_back(e);
        end
        for (int k = 0; k < 16; k++) begin
            if (mode == 1 && k > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_R = mat_r[k];
            in_I = mat_i[k];
            b = 0;
            while (!in_ready && b < 200) begin
                check("busy_while_not_ready", {31'b0, busy}, 32'd1);
                if (mode == 2) begin
                    in_R = 18'($urandom);
                    in_I = 18'($urandom);
                end
                @(posedge clk); #1;
                b++;
            end
            if (b == 200) check("ready_timeout", {31'b0, in_ready}, 32'd1);
            if (mode == 2 && k == 0) check("not_ready_cycles", b, 18);
            in_R = mat_r[k];
            in_I = mat_i[k];
            @(posedge clk); #1;
            last_xfer = cyc;
        end
        if (hold_after) begin
            in_valid = 1'b1;
            in_R = 18'($urandom);
            in_I = 18'($urandom);
        end else begin
            in_valid = 1'b0;
            in_R = '0;
            in_I = '0;
        end
    endtask

    task automatic drain();
        int b = 0;
        while ((q.size() != 0 || valid_o || busy) && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        check("drain_queue", q.size(), 0);
        check("drain_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int k = 0; k < 16; k++) begin
            mat_r[k] = 18'(int'($urandom_range(hi - lo, 0)) + lo);
            mat_i[k] = 18'(int'($urandom_range(hi - lo, 0)) + lo);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_o) begin
                if (run == 0) check("latency", cyc - last_xfer, 2);
                run++;
                seen = run;
                if (q.size() == 0) begin
                    check("unexpected_output", {31'b0, valid_o}, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("R_o", R_o, mon_e.r);
                    check("I_o", I_o, mon_e.i);
                    check("shift_o", {29'b0, shift_o}, {29'b0, mon_e.sh});
                end
            end else begin
                check("R_o_idle", R_o, 0);
                check("I_o_idle", I_o, 0);
                if (run > 0) begin
                    if (abort) begin
                        abort = 1'b0;
                    end else begin
                        check("burst_len", run, 16);
                        check("ready_after_gap", {31'b0, in_ready}, 32'd1);
                        bursts++;
                    end
                    run = 0;
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1'b1;
        in_valid = 1'b0;
        in_R = '0;
        in_I = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", {31'b0, valid_o}, 32'd0);
        check("rst_R_o", R_o, 0);
        check("rst_I_o", I_o, 0);
        check("rst_shift_o", {29'b0, shift_o}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        mon_en = 1'b1;

        // Gapped load, small values: clamped shift.
        for (int k = 0; k < 16; k++) begin
            mat_r[k] = 18'(k);
            mat_i[k] = 18'(-k);
        end
        load(1, 1'b0);
        drain();

        // Full-scale negative component: no shift.
        for (int k = 0; k < 16; k++) begin
            mat_r[k] = 18'(k * 3);
            mat_i[k] = 18'(k - 8);
        end
        mat_r[5] = -18'sd131072;
        load(0, 1'b0);
        drain();

        // Mid-range, back-to-back.
        for (int k = 0; k < 16; k++) begin
            mat_r[k] = 18'(k);
            mat_i[k] = 18'(-2 * k);
        end
        mat_r[3] = 18'sd1000;
        load(0, 1'b0);
        drain();

        // All zero, then all -1.
        for (int k = 0; k < 16; k++) begin
            mat_r[k] = '0;
            mat_i[k] = '0;
        end
        load(0, 1'b0);
        drain();
        for (int k = 0; k < 16; k++) begin
            mat_r[k] = '1;
            mat_i[k] = '1;
        end
        load(1, 1'b0);
        drain();

        // Backpressure: in_valid held through SCALE/EMIT/GAP with junk data.
        fill_random(-4096, 4095);
        load(0, 1'b1);
        fill_random(-50000, 50000);
        load(2, 1'b0);
        drain();

        // Reset during output entry 7.
        fill_random(-300, 300);
        load(0, 1'b0);
        b = 0;
        while (seen != 7 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (b == 100) check("rst_wait_seen", seen, 7);
        rst = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        check("midrst_valid_o", {31'b0, valid_o}, 32'd0);
        check("midrst_R_o", R_o, 0);
        check("midrst_I_o", I_o, 0);
        check("midrst_shift_o", {29'b0, shift_o}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        fill_random(-20, 20);
        load(0, 1'b0);
        drain();

        @(posedge clk); #1;
        check("bursts_completed", bursts, 8);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
